pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/rv32i_types.sv | 14 +
 rtl/pipe_stall_ctrl_if.sv | 28 ++
 rtl/port_resp_tracker.sv | 43 ++++
 rtl/pipe_stall_ctrl.sv | 98 +++++++++
 tb/tb_pipe_stall_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared pipeline types and constants.
// Provides memory-port index constants and a counter-width helper used to
// size saturating counters from their maximum value.
package rv32i_types;

  localparam int unsigned PORT_IMEM = 0;
  localparam int unsigned PORT_DMEM = 1;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : int'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline/memory side and the stall controller.
// master: drives req/resp/flush, observes advance and status.
// slave : the controller, observes req/resp/flush, drives advance and status.
interface pipe_stall_ctrl_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CNT_W     = 32
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] resp;
  logic                 flush;
  logic                 move_pipeline;
  logic                 flush_active;
  logic [NUM_PORTS-1:0] pending;
  logic [CNT_W-1:0]     stall_cycles;
  logic                 timeout_err;

  modport master (
    output req, resp, flush,
    input  move_pipeline, flush_active, pending, stall_cycles, timeout_err
  );

  modport slave (
    input  req, resp, flush,
    output move_pipeline, flush_active, pending, stall_cycles, timeout_err
  );

endinterface

// File: rtl/port_resp_tracker.sv
// Per-port response tracker.
// Remembers that a port's response already arrived while the pipeline is
// still held by another port, so the port stays ready until the next advance.
// Ports: clk, rst (async, active-low), req_i/resp_i (port handshake),
//        move_i (pipeline advance), ready_o (port allows advance),
//        pending_o (request seen, response not yet received).
module port_resp_tracker (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic resp_i,
  input  logic move_i,
  output logic ready_o,
  output logic pending_o
);

  logic done_q;
  logic done_d;

  // A response without a request is ignored; advance consumes the done bit.
  always_comb begin
    done_d = done_q;
    if (move_i) begin
      done_d = 1'b0;
    end else if (req_i && resp_i) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  // resp feeds ready directly so a same-cycle response advances with no delay.
  assign ready_o   = !req_i || done_q || resp_i;
  // Forced low while reset is asserted so status reads clean immediately.
  assign pending_o = req_i && !done_q && rst;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller.
// Advances the pipeline once every memory port with an outstanding request
// has responded, tracks squashed advances after a flush, counts stall
// cycles and raises a sticky watchdog error on a long stall.
// Ports: clk, rst (async, active-low), bus (slave side of pipe_stall_ctrl_if:
//        req/resp/flush in; move_pipeline, flush_active, pending,
//        stall_cycles, timeout_err out).
module pipe_stall_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_stall_ctrl_if.slave       bus
);

  localparam int unsigned FC_W = cnt_width(FLUSH_CYCLES);
  localparam int unsigned WD_W = cnt_width(TIMEOUT);

  logic [NUM_PORTS-1:0] ready_c;
  logic [NUM_PORTS-1:0] pending_c;
  logic                 move_c;

  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q,    wd_cnt_d;
  logic [CNT_W-1:0] stall_q,     stall_d;
  logic             err_q,       err_d;

  // One tracker per memory port.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    port_resp_tracker u_trk (
      .clk       (clk),
      .rst       (rst),
      .req_i     (bus.req[g]),
      .resp_i    (bus.resp[g]),
      .move_i    (move_c),
      .ready_o   (ready_c[g]),
      .pending_o (pending_c[g])
    );
  end

  assign move_c = &ready_c;

  // Next-state for flush window, watchdog, stall counter and error flag.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    stall_d     = stall_q;
    err_d       = err_q;

    // A new flush always restarts the window, even on a decrementing advance.
    if (bus.flush) begin
      flush_cnt_d = FC_W'(FLUSH_CYCLES);
    end else if (move_c && (flush_cnt_q != '0)) begin
      flush_cnt_d = flush_cnt_q - FC_W'(1);
    end

    // Watchdog saturates at TIMEOUT; with TIMEOUT=0 it stays at zero.
    if (move_c) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_W'(TIMEOUT)) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end

    if ((TIMEOUT != 0) && (wd_cnt_d == WD_W'(TIMEOUT))) begin
      err_d = 1'b1;
    end

    if (!move_c && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
      wd_cnt_q    <= '0;
      stall_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

  assign bus.move_pipeline = move_c;
  assign bus.flush_active  = (flush_cnt_q != '0);
  assign bus.pending       = pending_c;
  assign bus.stall_cycles  = stall_q;
  assign bus.timeout_err   = err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: each stimulus cycle pushes the
// hand-computed expected outputs; a monitor pops and compares mid-cycle.
module tb_pipe_stall_ctrl;

  localparam int unsigned NP = 2;
  localparam int unsigned FC = 2;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.NUM_PORTS(NP), .CNT_W(CW)) bus ();

  pipe_stall_ctrl #(
    .NUM_PORTS    (NP),
    .FLUSH_CYCLES (FC),
    .TIMEOUT      (TO),
    .CNT_W        (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic       mv;
    logic       fa;
    logic [1:0] pd;
    logic [3:0] st;
    logic       er;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Drive one cycle of stimulus just after the rising edge and queue the
  // outputs expected for that same cycle.
  task automatic step(input string name, input logic r, input logic [1:0] rq,
                      input logic [1:0] rs, input logic fl, input logic mv,
                      input logic fa, input logic [1:0] pd, input logic [3:0] st,
                      input logic er);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    bus.req  = rq;
    bus.resp = rs;
    bus.flush = fl;
    e.name = name; e.mv = mv; e.fa = fa; e.pd = pd; e.st = st; e.er = er;
    q.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      total++;
      if (bus.move_pipeline !== e.mv || bus.flush_active !== e.fa ||
          bus.pending !== e.pd || bus.stall_cycles !== e.st ||
          bus.timeout_err !== e.er) begin
        bad++;
        $display("FAIL %s: got mv=%b fa=%b pend=%b stall=%0d err=%b, want mv=%b fa=%b pend=%b stall=%0d err=%b",
                 e.name, bus.move_pipeline, bus.flush_active, bus.pending,
                 bus.stall_cycles, bus.timeout_err, e.mv, e.fa, e.pd, e.st, e.er);
      end
    end
  end

  initial begin
    rst       = 1'b0;
    bus.req   = '0;
    bus.resp  = '0;
    bus.flush = 1'b0;

    // Reset behaviour: move follows ready with done clear, pending forced low.
    step("rst_idle", 0, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0);
    step("rst_req",  0, 2'b11, 2'b00, 0, 0, 0, 2'b00, 0, 0);

    // Two ports, imem answers in cycle 1, dmem in cycle 4.
    step("two_c0", 1, 2'b11, 2'b00, 0, 0, 0, 2'b11, 0, 0);
    step("two_c1", 1, 2'b11, 2'b01, 0, 0, 0, 2'b11, 1, 0);
    step("two_c2", 1, 2'b11, 2'b00, 0, 0, 0, 2'b10, 2, 0);
    step("two_c3", 1, 2'b11, 2'b00, 0, 0, 0, 2'b10, 3, 0);
    step("two_c4", 1, 2'b11, 2'b10, 0, 1, 0, 2'b10, 4, 0);
    step("two_c5", 1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 4, 0);

    // Both responses in the same cycle: no stall at all.
    step("same_rst", 0, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0);
    step("same_c0",  1, 2'b11, 2'b11, 0, 1, 0, 2'b11, 0, 0);
    step("same_c1",  1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0);

    // Flush window of two advances, then a reload on the first flagged advance.
    step("fl_rst", 0, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0);
    step("fl_c0",  1, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, 0);
    step("fl_a1",  1, 2'b00, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    step("fl_a2",  1, 2'b00, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    step("fl_a3",  1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0);
    step("fl2_c0", 1, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0, 0);
    step("fl2_a1", 1, 2'b00, 2'b00, 1, 1, 1, 2'b00, 0, 0);
    step("fl2_a2", 1, 2'b00, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    step("fl2_a3", 1, 2'b00, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    step("fl2_a4", 1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0);

    // Watchdog: imem never answers; error from cycle 8, sticky after resp.
    step("to_rst", 0, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0);
    for (int k = 0; k < 8; k++)
      step("to_wait", 1, 2'b01, 2'b00, 0, 0, 0, 2'b01, 4'(k), 0);
    step("to_fire", 1, 2'b01, 2'b00, 0, 0, 0, 2'b01, 8, 1);
    step("to_resp", 1, 2'b01, 2'b01, 0, 1, 0, 2'b01, 9, 1);
    step("to_hold", 1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 9, 1);
    step("to_clr",  0, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0);

    // Stall counter saturation, then async reset in the middle of the wait.
    step("sat_c0", 1, 2'b10, 2'b00, 1, 0, 0, 2'b10, 0, 0);
    for (int k = 1; k < 20; k++)
      step("sat_wait", 1, 2'b10, 2'b00, 0, 0, 1, 2'b10,
           (k > 15) ? 4'd15 : 4'(k), (k >= 8) ? 1'b1 : 1'b0);
    step("sat_rst", 0, 2'b10, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    step("sat_rel", 1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0);

    // A response on a port without a request must not mark it done.
    step("ign_c0", 1, 2'b01, 2'b10, 0, 0, 0, 2'b01, 0, 0);
    step("ign_c1", 1, 2'b11, 2'b00, 0, 0, 0, 2'b11, 1, 0);
    step("ign_c2", 1, 2'b11, 2'b11, 0, 1, 0, 2'b11, 2, 0);
    step("ign_c3", 1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 2, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
